// File: rtl/data_register_pkg.sv
// Shared word type and defaults for the MISC-V datapath registers.
// Optional feature macro: DATA_REGISTER_WRITE_ENABLE_EN (see data_register.sv).
package data_register_pkg;

    localparam int unsigned DATA_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam word_t WORD_ZERO = '0;

endpackage

// File: rtl/data_register_if.sv
// Data bus bundle for a datapath register: load data, enable, registered output.
// reg_write is only consumed when DATA_REGISTER_WRITE_ENABLE_EN is defined.
interface data_register_if
    import data_register_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
);

    logic [WIDTH-1:0] reg_input;
    logic             reg_write;
    logic [WIDTH-1:0] reg_output;

    modport master (
        output reg_input,
        output reg_write,
        input  reg_output
    );

    modport slave (
        input  reg_input,
        input  reg_write,
        output reg_output
    );

endinterface

// File: rtl/data_register.sv
// Generic clocked storage register (PC, IR, pipeline temporaries).
// Define DATA_REGISTER_WRITE_ENABLE_EN to add the reg_write load enable.
module data_register
    import data_register_pkg::*;
#(
    parameter int unsigned      WIDTH       = DATA_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(WORD_ZERO)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] reg_input,
`ifdef DATA_REGISTER_WRITE_ENABLE_EN
    input  logic             reg_write,
`endif
    output logic [WIDTH-1:0] reg_output
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next value: load the input, or hold when the enable is low.
    always_comb begin
        data_d = data_q;
`ifdef DATA_REGISTER_WRITE_ENABLE_EN
        if (reg_write) begin
            data_d = reg_input;
        end
`else
        data_d = reg_input;
`endif
    end

    // Storage flops; synchronous active-low clear beats any load.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign reg_output = data_q;

endmodule

// File: tb/tb_data_register.sv
// Self-checking bench for data_register: directed vector table,
// hand-written mid-cycle sequences and randomized traffic vs. a model.
module tb_data_register;

    import data_register_pkg::*;

`ifdef DATA_REGISTER_WRITE_ENABLE_EN
    localparam bit WE_EN = 1'b1;
`else
    localparam bit WE_EN = 1'b0;
`endif

    typedef struct {
        logic  rst_n;
        logic  wr;
        word_t din;
        word_t exp;
        string name;
    } vec_t;

    logic  CLK = 1'b0;
    logic  reset;
    word_t model;
    int    n_tests = 0;
    int    n_fail  = 0;
    vec_t  vecs[12];

    data_register_if #(.WIDTH(DATA_WIDTH)) bus ();

    always #5 CLK = ~CLK;

    data_register #(
        .WIDTH      (DATA_WIDTH),
        .RESET_VALUE(WORD_ZERO)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .reg_input (bus.reg_input),
`ifdef DATA_REGISTER_WRITE_ENABLE_EN
        .reg_write (bus.reg_write),
`endif
        .reg_output(bus.reg_output)
    );

    task automatic check(input string name, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply inputs at the falling edge, let one rising edge happen,
    // update the reference model from the register rules, then settle.
    task automatic cyc(input logic r, input logic w, input word_t d);
        @(negedge CLK);
        reset         = r;
        bus.reg_write = w;
        bus.reg_input = d;
        @(posedge CLK);
        if (!r) model = WORD_ZERO;
        else if (!WE_EN || w) model = d;
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.reg_write = 1'b0;
        bus.reg_input = '0;
        model         = 'x;

        vecs[0]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, "reset_clear"};
        vecs[1]  = '{1'b1, 1'b1, 16'h8888, 16'h8888, "load_8888"};
        vecs[2]  = '{1'b1, 1'b1, 16'h1234, 16'h1234, "follow_1234"};
        vecs[3]  = '{1'b1, 1'b1, 16'hABCD, 16'hABCD, "follow_abcd"};
        vecs[4]  = '{1'b0, 1'b1, 16'h5555, 16'h0000, "reset_priority"};
        vecs[5]  = '{1'b1, 1'b1, 16'h5555, 16'h5555, "reset_release"};
        vecs[6]  = '{1'b1, 1'b0, 16'h0F0F,
                     WE_EN ? 16'h5555 : 16'h0F0F, "write_low"};
        vecs[7]  = '{1'b1, 1'b1, 16'h0F0F, 16'h0F0F, "write_high"};
        vecs[8]  = '{1'b0, 1'b0, 16'h1111, 16'h0000, "reset_no_write"};
        vecs[9]  = '{1'b0, 1'b1, 16'h2222, 16'h0000, "reset_held"};
        vecs[10] = '{1'b1, 1'b1, 16'h0001, 16'h0001, "load_lsb"};
        vecs[11] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, "load_ones"};

        foreach (vecs[i]) begin
            cyc(vecs[i].rst_n, vecs[i].wr, vecs[i].din);
            check(vecs[i].name, bus.reg_output, vecs[i].exp);
        end

        // Output must not move mid-cycle on input changes.
        cyc(1'b1, 1'b1, 16'h8888);
        @(negedge CLK);
        bus.reg_input = 16'h3C3C;
        #2;
        check("mid_cycle_input", bus.reg_output, 16'h8888);

        // Reset pulsed low strictly between edges has no effect.
        reset = 1'b0;
        #1;
        check("async_pulse_low", bus.reg_output, 16'h8888);
        reset = 1'b1;
        #1;
        check("async_pulse_rel", bus.reg_output, 16'h8888);

        // Next edge loads the changed input normally.
        @(posedge CLK);
        model = 16'h3C3C;
        #1;
        check("load_after_pulse", bus.reg_output, model);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic  r;
            logic  w;
            word_t d;
            r = ($urandom_range(0, 7) != 0);
            w = 1'($urandom_range(0, 1));
            d = word_t'($urandom);
            cyc(r, w, d);
            check("random", bus.reg_output, model);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
